// File: rtl/mips_enc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_enc_pkg
// Description : Shared MIPS encode/decode definitions. Holds the op-class
//               enum, primary opcode and R-type funct constants, and the
//               result type of the instruction encoder.
// Revision    : 1.0  initial release
// ============================================================================
package mips_enc_pkg;

  // Op classes carried by a decoded operation descriptor. Codes 13..15 are
  // undefined and treated as illegal by the encoder.
  typedef enum logic [3:0] {
    OPC_ADD  = 4'd0,
    OPC_SUB  = 4'd1,
    OPC_AND  = 4'd2,
    OPC_OR   = 4'd3,
    OPC_SLT  = 4'd4,
    OPC_SLLV = 4'd5,
    OPC_SRLV = 4'd6,
    OPC_SRAV = 4'd7,
    OPC_LW   = 4'd8,
    OPC_SW   = 4'd9,
    OPC_BEQ  = 4'd10,
    OPC_ADDI = 4'd11,
    OPC_J    = 4'd12
  } op_class_e;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instruction bits 5:0)
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_result_t;

  // R-type layout: opcode | rs | rt | rd | shamt(0) | funct
  function automatic logic [31:0] r_word(input logic [4:0] rs,
                                         input logic [4:0] rt,
                                         input logic [4:0] rd,
                                         input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : enc_fifo
// Description : Synchronous FIFO, DEPTH x WIDTH. Pointers carry one extra
//               wrap bit so full and empty are distinguished without a
//               separate flag. Read data is the head entry (fall-through).
// Ports       : clk, rst_n (async, active low)
//               push/wdata  - write when not full
//               pop/rdata   - retire head when not empty
//               full, empty, count (occupancy 0..DEPTH)
// Revision    : 1.0  initial release
// ============================================================================
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only observed after it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == CNT_FULL);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes operation descriptors into 32-bit MIPS instruction
//               words, buffers them in a FIFO and tags each retired word with
//               an incrementing word address. Illegal op classes are accepted
//               but dropped, and set a sticky err flag.
// Config      : define SHIFT_OPS_EN to encode SLLV/SRLV/SRAV; otherwise those
//               op classes are illegal.
// Ports       : in_valid/in_ready/in_op/in_rs/in_rt/in_rd/in_imm/in_target
//                 - descriptor input handshake
//               out_valid/out_ready/out_instr/out_addr
//                 - encoded word output handshake
//               err/err_clr - sticky illegal-op flag and its sync clear
//               count       - FIFO occupancy
// Revision    : 1.0  initial release
// ============================================================================
module instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [4:0]              in_rs,
  input  logic [4:0]              in_rt,
  input  logic [4:0]              in_rd,
  input  logic [15:0]             in_imm,
  input  logic [25:0]             in_target,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    err,
  input  logic                    err_clr,
  output logic [$clog2(DEPTH):0]  count
);

  function automatic enc_result_t encode(input logic [3:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm,
                                         input logic [25:0] target);
    enc_result_t res;
    res.legal = 1'b1;
    res.word  = '0;
    case (op)
      OPC_ADD:  res.word = r_word(rs, rt, rd, FN_ADD);
      OPC_SUB:  res.word = r_word(rs, rt, rd, FN_SUB);
      OPC_AND:  res.word = r_word(rs, rt, rd, FN_AND);
      OPC_OR:   res.word = r_word(rs, rt, rd, FN_OR);
      OPC_SLT:  res.word = r_word(rs, rt, rd, FN_SLT);
`ifdef SHIFT_OPS_EN
      OPC_SLLV: res.word = r_word(rs, rt, rd, FN_SLLV);
      OPC_SRLV: res.word = r_word(rs, rt, rd, FN_SRLV);
      OPC_SRAV: res.word = r_word(rs, rt, rd, FN_SRAV);
`endif
      OPC_LW:   res.word = {OP_LW,   rs, rt, imm};
      OPC_SW:   res.word = {OP_SW,   rs, rt, imm};
      OPC_BEQ:  res.word = {OP_BEQ,  rs, rt, imm};
      OPC_ADDI: res.word = {OP_ADDI, rs, rt, imm};
      OPC_J:    res.word = {OP_J, target};
      default:  res.legal = 1'b0;
    endcase
    return res;
  endfunction

  enc_result_t enc;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] last_instr;

  assign enc    = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
  assign accept = in_valid && in_ready;
  assign push   = accept && enc.legal;
  assign pop    = out_valid && out_ready;

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (enc.word),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // in_ready depends only on registered FIFO state, never on out_ready.
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  // When drained, keep presenting the most recently retired word.
  assign out_instr = fifo_empty ? last_instr : fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_instr <= '0;
      out_addr   <= '0;
    end else if (pop) begin
      last_instr <= fifo_rdata;
      out_addr   <= out_addr + ADDR_W'(1);
    end
  end

  // Setting on an illegal accept takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && !enc.legal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
`default_nettype wire
